// File: rtl/segway_uart_pkg.sv
// -----------------------------------------------------------------------------
// segway_uart_pkg
//   Shared types and constants for the rider command link transmitter.
//   - tx_state_t     : transmitter FSM states
//   - CMD_GO/CMD_STOP: command bytes understood by the Segway auth block
//   - BAUD_DIV_19200 : clocks per bit for 19200 baud from a 50 MHz clock
//   - SHIFT_W/FRAME_BITS and build_frame(): frame geometry, which depends on
//     the optional macro CMD_UART_TX_PARITY_EN (even parity, 8E1 framing).
// -----------------------------------------------------------------------------
package segway_uart_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam logic [7:0]  CMD_GO         = 8'h67;
    localparam logic [7:0]  CMD_STOP       = 8'h73;
    localparam int unsigned BAUD_DIV_19200 = 32'd2604;

`ifdef CMD_UART_TX_PARITY_EN
    // start + 8 data + parity; the stop bit is shifted in behind them
    localparam int unsigned SHIFT_W = 32'd10;
`else
    // start + 8 data; the stop bit is shifted in behind them
    localparam int unsigned SHIFT_W = 32'd9;
`endif

    localparam int unsigned FRAME_BITS = SHIFT_W + 32'd1;

`ifdef CMD_UART_TX_PARITY_EN
    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Shifter image of a frame, LSB first on the line. Ones are shifted in
    // from the top, so the stop bit appears once the payload has gone out.
    function automatic logic [SHIFT_W-1:0] build_frame(input logic [7:0] data);
`ifdef CMD_UART_TX_PARITY_EN
        return {even_parity(data), data, 1'b0};
`else
        return {data, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/cmd_tx_fifo.sv
// -----------------------------------------------------------------------------
// cmd_tx_fifo
//   Small byte FIFO feeding the command UART transmitter.
//   Ports:
//     clk, rst_n  clock / async active-low reset (empties the FIFO)
//     push        enqueue request; accepted if not full, or if a pop happens
//                 on the same edge
//     pop         dequeue request (ignored when empty)
//     din         byte to enqueue
//     dout        head entry (valid while !empty)
//     empty       no entries
//     full        registered: FIFO_DEPTH entries held
//     ovf         registered, sticky: a push was dropped while full
// -----------------------------------------------------------------------------
module cmd_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 32'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       ovf
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             do_push_s, do_pop_s;

    // Push/pop qualification and next-state for pointers, count and flags
    always_comb begin
        do_pop_s  = pop && (cnt_q != {CNT_W{1'b0}});
        // A pop on the same edge frees a slot, so a push while full still lands
        do_push_s = push && (!full_q || do_pop_s);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push && !do_push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        full_d = (cnt_d == CNT_FULL);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == {CNT_W{1'b0}});
    assign full  = full_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/cmd_uart_tx.sv
// -----------------------------------------------------------------------------
// cmd_uart_tx
//   Buffered UART transmitter for the rider command link. Bytes pushed with
//   trmt are queued in cmd_tx_fifo and sent LSB first as 8N1 frames, or 8E1
//   when the macro CMD_UART_TX_PARITY_EN is defined. Queued frames go out
//   back-to-back with no idle gap.
//   Parameters: BAUD_DIV (clocks per bit, 4..4095), FIFO_DEPTH (power of 2).
//   Ports:
//     clk, rst_n  clock / async active-low reset (aborts any frame)
//     trmt        push strobe, tx_data enqueued on every edge where trmt=1
//     tx_data     byte to enqueue
//     TX          serial line, idles high (driven straight from a register)
//     tx_done     1-cycle pulse in the last clock of each stop bit
//     busy        frame in progress or FIFO non-empty
//     full        FIFO full (registered)
//     ovf         sticky push-dropped flag (registered)
// -----------------------------------------------------------------------------
module cmd_uart_tx
    import segway_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_19200,
    parameter int unsigned FIFO_DEPTH = 32'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    localparam logic [11:0] BAUD_LAST     = 12'(BAUD_DIV - 32'd1);
    // tx_done is registered, so it is set one count early to land in the last clock
    localparam logic [11:0] BAUD_PRE_LAST = 12'(BAUD_DIV - 32'd2);
    localparam logic [3:0]  LAST_BIT      = 4'(FRAME_BITS - 32'd1);

    tx_state_t           state_q, state_d;
    logic [11:0]         baud_q, baud_d;
    logic [3:0]          bit_q, bit_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                done_q, done_d;
    logic                pop_s;
    logic [7:0]          fifo_dout_s;
    logic                fifo_empty_s;

    cmd_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trmt),
        .pop   (pop_s),
        .din   (tx_data),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (full),
        .ovf   (ovf)
    );

    // FSM next-state, baud/bit counters, shifter and FIFO pop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        pop_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = build_frame(fifo_dout_s);
                    baud_d  = 12'd0;
                    bit_d   = 4'd0;
                    state_d = SHIFT;
                end else begin
                    shift_d = {SHIFT_W{1'b1}};
                end
            end

            SHIFT: begin
                done_d = (bit_q == LAST_BIT) && (baud_q == BAUD_PRE_LAST);
                if (baud_q == BAUD_LAST) begin
                    baud_d = 12'd0;
                    if (bit_q == LAST_BIT) begin
                        bit_d = 4'd0;
                        // Reload on the same edge so the next start bit follows immediately
                        if (!fifo_empty_s) begin
                            pop_s   = 1'b1;
                            shift_d = build_frame(fifo_dout_s);
                        end else begin
                            shift_d = {SHIFT_W{1'b1}};
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[SHIFT_W-1:1]};
                    end
                end else begin
                    baud_d = baud_q + 12'd1;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = 12'd0;
                bit_d   = 4'd0;
                shift_d = {SHIFT_W{1'b1}};
            end
        endcase
    end

    // State, counter, shifter and tx_done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 12'd0;
            bit_q   <= 4'd0;
            shift_q <= {SHIFT_W{1'b1}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    // Shifter LSB is the line; it holds all ones whenever no frame is active
    assign TX      = shift_q[0];
    assign tx_done = done_q;
    assign busy    = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_cmd_uart_tx
//   Self-checking bench for cmd_uart_tx with BAUD_DIV=16, FIFO_DEPTH=4.
//   A behavioural serial receiver decodes TX into a byte queue that is compared
//   with the bytes the bench expects to be sent. Honours CMD_UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_cmd_uart_tx;
    import segway_uart_pkg::*;

    localparam int BD = 16;
`ifdef CMD_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CLKS = BD * NB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       trmt    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, tx_done, busy, full, ovf;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    cmd_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .busy    (busy),
        .full    (full),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level of bit k of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return d[k-1];
        else if (k == NB - 1) return 1'b1;
        else return ^d;
    endfunction

    // True when a received frame has a valid start, stop and (optional) parity
    function automatic logic frame_ok(input logic [NB-1:0] f);
        logic ok;
        ok = (f[0] == 1'b0) && (f[NB-1] == 1'b1);
`ifdef CMD_UART_TX_PARITY_EN
        ok = ok && (f[9] == ^f[8:1]);
`endif
        return ok;
    endfunction

    // Behavioural receiver: samples mid-bit, aborts on reset
    logic [7:0]    rx_q[$];
    int            rx_start_q[$];
    int            rx_ferr = 0;
    logic          rx_act  = 1'b0;
    int            rx_cnt  = 0;
    logic [NB-1:0] rx_bits = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (TX === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % BD == BD / 2 - 1) begin
                if (rx_cnt / BD == NB - 1) begin
                    rx_act <= 1'b0;
                    if (!frame_ok({TX, rx_bits[NB-2:0]})) rx_ferr <= rx_ferr + 1;
                    rx_q.push_back(rx_bits[8:1]);
                end else begin
                    rx_bits[rx_cnt / BD] <= TX;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]    exp_q[$];
        logic [7:0]    burst[4];
        logic [NB-1:0] samp;
        logic [7:0]    d;
        int            t, bcnt, dcnt, done_at, base, lows;

        burst[0] = CMD_GO; burst[1] = CMD_STOP; burst[2] = 8'hA5; burst[3] = 8'h00;
        samp = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", tx_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- 1: single byte, latency, bit pattern, tx_done position ----
        trmt = 1'b1; tx_data = CMD_GO; exp_q.push_back(CMD_GO);
        @(negedge clk);
        trmt = 1'b0; tx_data = 8'($urandom);
        chk("t1_busy_after_push", busy, 1);
        chk("t1_tx_before_pop", TX, 1);
        @(negedge clk);
        chk("t1_tx_start", TX, 0);
        dcnt = 0; done_at = 0;
        for (int c = 1; c <= FRAME_CLKS + BD; c++) begin
            if (c > 1) @(negedge clk);
            if ((c - 1) < FRAME_CLKS && (c - 1) % BD == BD / 2) samp[(c - 1) / BD] = TX;
            if (tx_done) begin dcnt++; done_at = c; end
        end
        for (int k = 0; k < NB; k++) chk($sformatf("t1_bit%0d", k), samp[k], exp_bit(CMD_GO, k));
        chk("t1_done_cnt", dcnt, 1);
        chk("t1_done_at", done_at, FRAME_CLKS);
        chk("t1_idle_tx", TX, 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_rx_n", rx_q.size(), exp_q.size());
        if (rx_q.size() > 0) chk("t1_rx_data", rx_q[0], 8'h67);

        // ---- 2: burst of four, back-to-back frames, busy length ----
        base = rx_start_q.size();
        for (int i = 0; i < 4; i++) begin
            trmt = 1'b1; tx_data = burst[i]; exp_q.push_back(burst[i]);
            @(negedge clk);
            if (i == 0) chk("t2_busy_rise", busy, 1);
        end
        trmt = 1'b0;
        chk("t2_full_count3", full, 0);
        bcnt = 4; dcnt = 0; t = 0;
        while (busy && t < 5000) begin
            @(negedge clk); t++;
            if (busy) bcnt++;
            if (tx_done) dcnt++;
        end
        chk("t2_busy_timeout", (t < 5000), 1);
        chk("t2_busy_len", bcnt, 4 * FRAME_CLKS + 1);
        chk("t2_done_pulses", dcnt, 4);
        chk("t2_frames", rx_start_q.size() - base, 4);
        if (rx_start_q.size() - base == 4)
            for (int i = 0; i < 3; i++)
                chk($sformatf("t2_gap%0d", i), rx_start_q[base+i+1] - rx_start_q[base+i], FRAME_CLKS);

        // ---- 3: fill while in flight, push on pop edge, overflow ----
        for (int i = 0; i < 5; i++) begin
            trmt = 1'b1; d = 8'($urandom_range(0, 254)); tx_data = d; exp_q.push_back(d);
            @(negedge clk);
        end
        trmt = 1'b0;
        chk("t3_full", full, 1);
        chk("t3_ovf_clear", ovf, 0);
        t = 0;
        while (!tx_done && t < 1000) begin @(negedge clk); t++; end
        chk("t3_done_timeout", (t < 1000), 1);
        trmt = 1'b1; d = 8'($urandom_range(0, 254)); tx_data = d; exp_q.push_back(d);
        @(negedge clk);
        chk("t3_full_after_pushpop", full, 1);
        chk("t3_ovf_after_pushpop", ovf, 0);
        tx_data = 8'hFF;
        @(negedge clk);
        trmt = 1'b0;
        chk("t3_ovf_set", ovf, 1);
        chk("t3_full_hold", full, 1);
        t = 0;
        while (busy && t < 10000) begin @(negedge clk); t++; end
        chk("t3_busy_timeout", (t < 10000), 1);
        chk("t3_rx_n", rx_q.size(), exp_q.size());
        if (rx_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("t3_rx%0d", i), rx_q[i], exp_q[i]);

        // ---- 4: reset in the middle of a frame ----
        trmt = 1'b1; tx_data = 8'($urandom_range(0, 255));
        @(negedge clk);
        trmt = 1'b0;
        t = 0;
        while (TX !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        chk("t4_start_timeout", (t < 100), 1);
        repeat (69) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_tx", TX, 1);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_full", full, 0);
        chk("t4_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (2 * FRAME_CLKS) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        chk("t4_quiet_tx", lows, 0);
        chk("t4_quiet_busy", busy, 0);
        chk("t4_rx_n", rx_q.size(), exp_q.size());
        trmt = 1'b1; d = 8'($urandom_range(0, 255)); tx_data = d; exp_q.push_back(d);
        @(negedge clk);
        trmt = 1'b0;
        t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        chk("t4_busy_timeout", (t < 1000), 1);
        chk("t4_rx_n_after", rx_q.size(), exp_q.size());
        if (rx_q.size() == exp_q.size()) chk("t4_rx_last", rx_q[rx_q.size()-1], d);

        chk("rx_framing", rx_ferr, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
